ocx_dlx_tx_gbx_ctl: RTL and testbench

OCX_DLX_TX_GBX_CTL -- requirements
Module: ocx_dlx_tx_gbx_ctl

---
 rtl/ocx_dlx_pkg.sv | 31 +++
 rtl/ocx_dlx_gb_seq_cnt.sv | 42 ++++
 rtl/ocx_dlx_tx_gbx_ctl.sv | 198 +++++++++++++++++++
 tb/tb_ocx_dlx_tx_gbx_ctl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ocx_dlx_pkg.sv
// ---------------------------------------------------------------------------
// ocx_dlx_pkg
//   Shared definitions for the DLx TX gearbox control slice:
//     - dlx_tx_state_e : training FSM state encoding
//     - SEQ_MAX        : last gearbox sequence value (counter wraps 65 -> 0)
//     - STALL_SEQ      : value of seq[6:1] at which the TX queue must hold
//                        its data (seq 64 and 65)
//     - sat_inc16      : saturating 16-bit increment shared by the
//                        state-cycle counter and the watchdog
// ---------------------------------------------------------------------------
package ocx_dlx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ZEROS  = 3'd1,
    ST_PAT_A  = 3'd2,
    ST_PAT_B  = 3'd3,
    ST_SYNC   = 3'd4,
    ST_TRAIN  = 3'd5,
    ST_ACTIVE = 3'd6,
    ST_FAILED = 3'd7
  } dlx_tx_state_e;

  localparam logic [6:0] SEQ_MAX   = 7'd65;
  localparam logic [5:0] STALL_SEQ = 6'd32;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/ocx_dlx_gb_seq_cnt.sv
// ---------------------------------------------------------------------------
// ocx_dlx_gb_seq_cnt
//   Gearbox sequence counter and TX queue stall decode.
//   The counter advances once per cycle over 0..65 and wraps to 0. It is
//   held at 0 while the gearbox is in reset so that the first cycle after
//   gearbox reset release always carries seq 0.
//
// Ports
//   i_clk      in   1  clock, posedge
//   i_rst      in   1  synchronous active-high reset
//   i_gb_reset in   1  gearbox reset (holds the counter at 0)
//   o_seq      out  7  registered sequence value, 0..65
//   o_stall    out  1  1 at seq 64 and 65 (decode of the registered seq)
// ---------------------------------------------------------------------------
module ocx_dlx_gb_seq_cnt
  import ocx_dlx_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_gb_reset,
  output logic [6:0] o_seq,
  output logic       o_stall
);

  logic [6:0] r_seq;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_gb_reset) begin
      r_seq <= 7'd0;
    end else if (r_seq == SEQ_MAX) begin
      r_seq <= 7'd0;
    end else begin
      r_seq <= r_seq + 7'd1;
    end
  end

  assign o_seq   = r_seq;
  // Upper six bits equal 32 exactly for seq 64 and 65, the two slots the
  // gearbox uses to absorb the accumulated header bits.
  assign o_stall = (r_seq[6:1] == STALL_SEQ);

endmodule

// File: rtl/ocx_dlx_tx_gbx_ctl.sv
// ---------------------------------------------------------------------------
// ocx_dlx_tx_gbx_ctl
//   DLx transmit gearbox control: link training FSM plus the gearbox
//   sequence counter (ocx_dlx_gb_seq_cnt).
//
//   Training walks IDLE -> ZEROS -> PAT_A -> PAT_B -> SYNC -> TRAIN ->
//   ACTIVE. Dropping ctl_start_train returns to IDLE from any state; losing
//   the receiver link in ACTIVE restarts training from ZEROS.
//
//   Optional feature (define OCX_DLX_TX_GBX_CTL_TIMEOUT_EN):
//     16-bit watchdog over PAT_A..TRAIN; reaching TIMEOUT_CYC moves the FSM
//     to FAILED. Without the macro the watchdog does not exist and
//     ctl_train_failed is constant 0.
//
// Parameters
//   ZERO_CYC     minimum cycles spent in ZEROS before aligning to seq 65
//   PAT_MIN_CYC  minimum cycles spent in each of PAT_A and PAT_B
//   SYNC_CYC     cycles spent in SYNC
//   TIMEOUT_CYC  watchdog limit (only with the macro defined)
//
// Ports
//   dlx_clk                 in   1  clock, posedge
//   dlx_reset               in   1  synchronous active-high reset
//   ctl_start_train         in   1  level: 1 train/hold link, 0 go IDLE
//   orx_otx_a_det           in   1  receiver saw pattern A
//   orx_otx_b_det           in   1  receiver saw pattern B
//   orx_otx_link_up         in   1  receiver training complete
//   ctl_gb_reset            out  1  gearbox reset (IDLE)
//   ctl_gb_seq              out  7  gearbox sequence 0..65
//   ctl_gb_train            out  1  control sync headers (TRAIN)
//   ctl_gb_tx_zeros         out  1  send zeros (IDLE, ZEROS, FAILED)
//   ctl_gb_tx_a_pattern     out  1  send pattern A (PAT_A)
//   ctl_gb_tx_b_pattern     out  1  send pattern B (PAT_B)
//   ctl_gb_tx_sync_pattern  out  1  send sync pattern (SYNC)
//   ctl_que_stall           out  1  TX queue holds data (seq 64, 65)
//   ctl_train_failed        out  1  training failed (FAILED)
//   ctl_link_up             out  1  link active (ACTIVE)
//
//   All outputs are decodes of registered state or registered counters.
// ---------------------------------------------------------------------------
module ocx_dlx_tx_gbx_ctl
  import ocx_dlx_pkg::*;
#(
  parameter int ZERO_CYC    = 128,
  parameter int PAT_MIN_CYC = 64,
  parameter int SYNC_CYC    = 66,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic       dlx_clk,
  input  logic       dlx_reset,
  input  logic       ctl_start_train,
  input  logic       orx_otx_a_det,
  input  logic       orx_otx_b_det,
  input  logic       orx_otx_link_up,
  output logic       ctl_gb_reset,
  output logic [6:0] ctl_gb_seq,
  output logic       ctl_gb_train,
  output logic       ctl_gb_tx_zeros,
  output logic       ctl_gb_tx_a_pattern,
  output logic       ctl_gb_tx_b_pattern,
  output logic       ctl_gb_tx_sync_pattern,
  output logic       ctl_que_stall,
  output logic       ctl_train_failed,
  output logic       ctl_link_up
);

  // r_cnt holds the number of cycles already completed in the current
  // state, so "r_cnt >= N-1" means the current cycle is the N-th one.
  localparam logic [15:0] ZERO_LAST = 16'(ZERO_CYC - 1);
  localparam logic [15:0] PAT_LAST  = 16'(PAT_MIN_CYC - 1);
  localparam logic [15:0] SYNC_LAST = 16'(SYNC_CYC - 1);

  dlx_tx_state_e r_state;
  dlx_tx_state_e w_next;
  logic [15:0]   r_cnt;
  logic          w_timeout;

  ocx_dlx_gb_seq_cnt u_seq_cnt (
    .i_clk      (dlx_clk),
    .i_rst      (dlx_reset),
    .i_gb_reset (ctl_gb_reset),
    .o_seq      (ctl_gb_seq),
    .o_stall    (ctl_que_stall)
  );

`ifdef OCX_DLX_TX_GBX_CTL_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

  logic [15:0] r_wdog;
  logic        w_in_window;

  // The watchdog spans the whole PAT_A..TRAIN window; it is not cleared on
  // transitions inside the window, only when the FSM leaves it.
  assign w_in_window = (r_state == ST_PAT_A) || (r_state == ST_PAT_B) ||
                       (r_state == ST_SYNC)  || (r_state == ST_TRAIN);

  always_ff @(posedge dlx_clk) begin
    if (dlx_reset || !w_in_window) begin
      r_wdog <= 16'd0;
    end else begin
      r_wdog <= sat_inc16(r_wdog);
    end
  end

  // r_wdog counts completed cycles, so this fires on the TIMEOUT_CYC-th
  // cycle inside the window.
  assign w_timeout = w_in_window && (r_wdog >= TMO_LAST);
`else
  logic w_unused_tmo;

  assign w_timeout    = 1'b0;
  assign w_unused_tmo = (TIMEOUT_CYC != 0);
`endif

  // State register and state-cycle counter
  always_ff @(posedge dlx_clk) begin
    if (dlx_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= 16'd0;
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? 16'd0 : sat_inc16(r_cnt);
    end
  end

  // Next-state logic; later assignments take priority: dropping
  // ctl_start_train beats a timeout, and a timeout beats any progress.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (ctl_start_train) w_next = ST_ZEROS;
      end
      ST_ZEROS: begin
        // Leaving on seq 65 makes PAT_A begin on seq 0.
        if ((r_cnt >= ZERO_LAST) && (ctl_gb_seq == SEQ_MAX)) w_next = ST_PAT_A;
      end
      ST_PAT_A: begin
        if ((r_cnt >= PAT_LAST) && orx_otx_a_det) w_next = ST_PAT_B;
      end
      ST_PAT_B: begin
        if ((r_cnt >= PAT_LAST) && orx_otx_b_det) w_next = ST_SYNC;
      end
      ST_SYNC: begin
        if (r_cnt >= SYNC_LAST) w_next = ST_TRAIN;
      end
      ST_TRAIN: begin
        if (orx_otx_link_up) w_next = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (!orx_otx_link_up) w_next = ST_ZEROS;
      end
      ST_FAILED: begin
        w_next = ST_FAILED;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
    if (w_timeout)        w_next = ST_FAILED;
    if (!ctl_start_train) w_next = ST_IDLE;
  end

  // Output decode of the registered state
  always_comb begin
    ctl_gb_reset           = 1'b0;
    ctl_gb_train           = 1'b0;
    ctl_gb_tx_zeros        = 1'b0;
    ctl_gb_tx_a_pattern    = 1'b0;
    ctl_gb_tx_b_pattern    = 1'b0;
    ctl_gb_tx_sync_pattern = 1'b0;
    ctl_train_failed       = 1'b0;
    ctl_link_up            = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ctl_gb_reset    = 1'b1;
        ctl_gb_tx_zeros = 1'b1;
      end
      ST_ZEROS:  ctl_gb_tx_zeros        = 1'b1;
      ST_PAT_A:  ctl_gb_tx_a_pattern    = 1'b1;
      ST_PAT_B:  ctl_gb_tx_b_pattern    = 1'b1;
      ST_SYNC:   ctl_gb_tx_sync_pattern = 1'b1;
      ST_TRAIN:  ctl_gb_train           = 1'b1;
      ST_ACTIVE: ctl_link_up            = 1'b1;
      ST_FAILED: begin
        ctl_gb_tx_zeros = 1'b1;
`ifdef OCX_DLX_TX_GBX_CTL_TIMEOUT_EN
        ctl_train_failed = 1'b1;
`endif
      end
      default: begin
        ctl_gb_reset    = 1'b1;
        ctl_gb_tx_zeros = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_ocx_dlx_tx_gbx_ctl.sv
`timescale 1ns/1ps
module tb_ocx_dlx_tx_gbx_ctl;

  localparam int ZC = 8;
  localparam int PM = 4;
  localparam int SC = 4;
  localparam int TO = 200;
`ifdef OCX_DLX_TX_GBX_CTL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       st = 1'b0, adet = 1'b0, bdet = 1'b0, lu = 1'b0;
  logic       ctl_gb_reset, ctl_gb_train, ctl_gb_tx_zeros;
  logic       ctl_gb_tx_a_pattern, ctl_gb_tx_b_pattern, ctl_gb_tx_sync_pattern;
  logic       ctl_que_stall, ctl_train_failed, ctl_link_up;
  logic [6:0] ctl_gb_seq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ocx_dlx_tx_gbx_ctl #(
    .ZERO_CYC(ZC), .PAT_MIN_CYC(PM), .SYNC_CYC(SC), .TIMEOUT_CYC(TO)
  ) dut (
    .dlx_clk                (clk),
    .dlx_reset              (rst),
    .ctl_start_train        (st),
    .orx_otx_a_det          (adet),
    .orx_otx_b_det          (bdet),
    .orx_otx_link_up        (lu),
    .ctl_gb_reset           (ctl_gb_reset),
    .ctl_gb_seq             (ctl_gb_seq),
    .ctl_gb_train           (ctl_gb_train),
    .ctl_gb_tx_zeros        (ctl_gb_tx_zeros),
    .ctl_gb_tx_a_pattern    (ctl_gb_tx_a_pattern),
    .ctl_gb_tx_b_pattern    (ctl_gb_tx_b_pattern),
    .ctl_gb_tx_sync_pattern (ctl_gb_tx_sync_pattern),
    .ctl_que_stall          (ctl_que_stall),
    .ctl_train_failed       (ctl_train_failed),
    .ctl_link_up            (ctl_link_up)
  );

  a_one_select: assert property (@(posedge clk) disable iff (rst)
    $onehot0({ctl_gb_tx_zeros, ctl_gb_tx_a_pattern, ctl_gb_tx_b_pattern, ctl_gb_tx_sync_pattern}))
    else begin
      bad++;
      $display("FAIL one_select: selects=%b required at most one set", {ctl_gb_tx_zeros,
               ctl_gb_tx_a_pattern, ctl_gb_tx_b_pattern, ctl_gb_tx_sync_pattern});
    end

  // Reference model: phase of the training sequence, cycles spent in the
  // phase, gearbox sequence and cycles spent in the watchdog window.
  localparam int M_IDLE = 0, M_ZEROS = 1, M_PAT_A = 2, M_PAT_B = 3;
  localparam int M_SYNC = 4, M_TRAIN = 5, M_ACTIVE = 6, M_FAILED = 7;
  int m_phase = M_IDLE, m_t = 0, m_seq = 0, m_wd = 0;

  task automatic model_step(input logic r, s, a, b, l);
    int  nxt;
    bit  win;
    int  here;
    if (r) begin
      m_phase = M_IDLE; m_t = 0; m_seq = 0; m_wd = 0;
      return;
    end
    here = m_t + 1;
    win  = (m_phase >= M_PAT_A) && (m_phase <= M_TRAIN);
    nxt  = m_phase;
    case (m_phase)
      M_IDLE:   if (s) nxt = M_ZEROS;
      M_ZEROS:  if (here >= ZC && m_seq == 65) nxt = M_PAT_A;
      M_PAT_A:  if (here >= PM && a) nxt = M_PAT_B;
      M_PAT_B:  if (here >= PM && b) nxt = M_SYNC;
      M_SYNC:   if (here >= SC) nxt = M_TRAIN;
      M_TRAIN:  if (l) nxt = M_ACTIVE;
      M_ACTIVE: if (!l) nxt = M_ZEROS;
      default:  ;
    endcase
    if (TMO_EN && win && (m_wd + 1 >= TO)) nxt = M_FAILED;
    if (!s) nxt = M_IDLE;
    m_seq = (m_phase == M_IDLE) ? 0 : (m_seq + 1) % 66;
    m_wd  = win ? m_wd + 1 : 0;
    m_t   = (nxt != m_phase) ? 0 : ((m_t < 65535) ? m_t + 1 : m_t);
    m_phase = nxt;
  endtask

  function automatic logic [15:0] exp_vec();
    logic [6:0] sq;
    sq = 7'(m_seq);
    return {m_phase == M_IDLE, sq, m_phase == M_TRAIN,
            (m_phase == M_IDLE) || (m_phase == M_ZEROS) || (m_phase == M_FAILED),
            m_phase == M_PAT_A, m_phase == M_PAT_B, m_phase == M_SYNC,
            m_seq >= 64, TMO_EN && (m_phase == M_FAILED), m_phase == M_ACTIVE};
  endfunction

  function automatic logic [15:0] dut_vec();
    return {ctl_gb_reset, ctl_gb_seq, ctl_gb_train, ctl_gb_tx_zeros,
            ctl_gb_tx_a_pattern, ctl_gb_tx_b_pattern, ctl_gb_tx_sync_pattern,
            ctl_que_stall, ctl_train_failed, ctl_link_up};
  endfunction

  // Advance one clock: inputs are latched by the model as the DUT sees
  // them at the edge, outputs are then settled 1ns after the edge.
  task automatic tick();
    logic r, s, a, b, l;
    r = rst; s = st; a = adet; b = bdet; l = lu;
    @(posedge clk);
    model_step(r, s, a, b, l);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; st = 1'b0;
    repeat (3) tick();
    total++;
    if (dut_vec() !== 16'h8040) begin
      bad++; $display("FAIL reset_values: got %h required %h", dut_vec(), 16'h8040);
    end
    st = 1'b1; adet = 1'b1; bdet = 1'b1; lu = 1'b1;
    tick();
    total++;
    if (dut_vec() !== 16'h8040) begin
      bad++; $display("FAIL reset_priority: got %h required %h", dut_vec(), 16'h8040);
    end
    total++;
    if (dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL reset_model: got %h required %h", dut_vec(), exp_vec());
    end
    st = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_idle();
    int stall_seen = 0;
    st = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (ctl_que_stall === 1'b1) stall_seen++;
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL idle_cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
    total++;
    if (ctl_gb_reset !== 1'b1 || ctl_gb_tx_zeros !== 1'b1) begin
      bad++; $display("FAIL idle_state: gb_reset=%b zeros=%b required 1 1", ctl_gb_reset, ctl_gb_tx_zeros);
    end
    total++;
    if (stall_seen !== 0) begin
      bad++; $display("FAIL idle_stall: stall cycles %0d required 0", stall_seen);
    end
  endtask

  task automatic test_train_up();
    int a_len = 0, b_len = 0, a_seq = -1, zero_len = 0;
    bit seen_sync = 0, seen_train = 0, up = 0;
    st = 1'b1; adet = 1'b1; bdet = 1'b1; lu = 1'b1;
    for (int i = 0; i < 400 && !up; i++) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL train_cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
      if (ctl_gb_tx_zeros === 1'b1) zero_len++;
      if (ctl_gb_tx_a_pattern === 1'b1) begin
        if (a_len == 0) a_seq = int'(ctl_gb_seq);
        a_len++;
      end
      if (ctl_gb_tx_b_pattern === 1'b1) b_len++;
      if (ctl_gb_tx_sync_pattern === 1'b1) seen_sync = 1;
      if (ctl_gb_train === 1'b1) seen_train = 1;
      if (ctl_link_up === 1'b1) up = 1;
    end
    total++;
    if (!up) begin bad++; $display("FAIL train_reach_active: link_up=%b required 1", ctl_link_up); end
    total++;
    if (a_seq != 0) begin bad++; $display("FAIL pat_a_start_seq: got %0d required 0", a_seq); end
    total++;
    if (a_len != PM) begin bad++; $display("FAIL pat_a_len: got %0d required %0d", a_len, PM); end
    total++;
    if (b_len != PM) begin bad++; $display("FAIL pat_b_len: got %0d required %0d", b_len, PM); end
    total++;
    if (zero_len != 66) begin bad++; $display("FAIL zeros_len: got %0d required 66", zero_len); end
    total++;
    if (!(seen_sync && seen_train)) begin
      bad++; $display("FAIL train_phases: sync=%0d train=%0d required 1 1", seen_sync, seen_train);
    end
    for (int i = 0; i < 140; i++) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL active_cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_link_drop();
    bit up = 0;
    lu = 1'b0;
    tick();
    total++;
    if (ctl_link_up !== 1'b0 || ctl_gb_tx_zeros !== 1'b1) begin
      bad++; $display("FAIL link_drop: link_up=%b zeros=%b required 0 1", ctl_link_up, ctl_gb_tx_zeros);
    end
    lu = 1'b1;
    for (int i = 0; i < 400 && !up; i++) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL retrain_cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
      if (ctl_link_up === 1'b1) up = 1;
    end
    total++;
    if (!up) begin bad++; $display("FAIL retrain_reach_active: link_up=%b required 1", ctl_link_up); end
  endtask

  task automatic test_reset_in_sync();
    bit in_sync = 0, in_a = 0;
    st = 1'b0; tick();
    st = 1'b1; adet = 1'b1; bdet = 1'b1; lu = 1'b1;
    for (int i = 0; i < 400 && !in_sync; i++) begin
      tick();
      if (ctl_gb_tx_sync_pattern === 1'b1) in_sync = 1;
    end
    total++;
    if (!in_sync) begin bad++; $display("FAIL reach_sync: sync=%b required 1", ctl_gb_tx_sync_pattern); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (dut_vec() !== 16'h8040) begin
      bad++; $display("FAIL reset_in_sync: got %h required %h", dut_vec(), 16'h8040);
    end
    for (int i = 0; i < 200 && !in_a; i++) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL post_reset_cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
      if (ctl_gb_tx_a_pattern === 1'b1) in_a = 1;
    end
    total++;
    if (!in_a) begin bad++; $display("FAIL post_reset_pat_a: a_pattern=%b required 1", ctl_gb_tx_a_pattern); end
  endtask

  task automatic test_timeout();
    int a_cnt = 0, fail_at = -1;
    bit in_a = 0;
    st = 1'b0; tick();
    st = 1'b1; adet = 1'b0; bdet = 1'b1; lu = 1'b1;
    for (int i = 0; i < 300 && !in_a; i++) begin
      tick();
      if (ctl_gb_tx_a_pattern === 1'b1) in_a = 1;
    end
    total++;
    if (!in_a) begin bad++; $display("FAIL tmo_reach_pat_a: a_pattern=%b required 1", ctl_gb_tx_a_pattern); end
    a_cnt = 1;
    for (int i = 0; i < 300 && fail_at < 0; i++) begin
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL tmo_cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
      if (ctl_train_failed === 1'b1) fail_at = a_cnt;
      else if (ctl_gb_tx_a_pattern === 1'b1) a_cnt++;
    end
`ifdef OCX_DLX_TX_GBX_CTL_TIMEOUT_EN
    total++;
    if (fail_at != TO) begin bad++; $display("FAIL tmo_failed_at: got %0d required %0d", fail_at, TO); end
    adet = 1'b1;
    repeat (5) tick();
    total++;
    if (ctl_train_failed !== 1'b1 || ctl_gb_tx_zeros !== 1'b1) begin
      bad++; $display("FAIL tmo_hold: failed=%b zeros=%b required 1 1", ctl_train_failed, ctl_gb_tx_zeros);
    end
`else
    total++;
    if (fail_at != -1 || a_cnt != 301 || ctl_gb_tx_a_pattern !== 1'b1) begin
      bad++; $display("FAIL tmo_stay_pat_a: fail_at=%0d a_cycles=%0d required -1 301", fail_at, a_cnt);
    end
`endif
    st = 1'b0;
    tick();
    total++;
    if (dut_vec() !== 16'h0040 && dut_vec() !== exp_vec()) begin
      bad++; $display("FAIL stop_to_idle: got %h required %h", dut_vec(), exp_vec());
    end
    total++;
    if (ctl_gb_reset !== 1'b1 || ctl_train_failed !== 1'b0) begin
      bad++; $display("FAIL stop_idle_state: gb_reset=%b failed=%b required 1 0", ctl_gb_reset, ctl_train_failed);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 1500; i++) begin
      rst  = ($urandom_range(0, 299) == 0);
      st   = ($urandom_range(0, 59) != 0);
      adet = ($urandom_range(0, 3) != 0);
      bdet = ($urandom_range(0, 3) != 0);
      lu   = ($urandom_range(0, 7) != 0);
      tick();
      total++;
      if (dut_vec() !== exp_vec()) begin
        bad++; $display("FAIL random_cyc%0d: got %h required %h", i, dut_vec(), exp_vec());
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_train_up();
    test_link_drop();
    test_reset_in_sync();
    test_timeout();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
